// File: rtl/fp_align_add_pkg.sv
// Shared single-precision constants, stage bundles and result-pattern helpers for
// the align/add back end.
package fp_align_add_pkg;

    localparam int FP_MW      = 24;
    localparam int FP_EW      = 8;
    localparam int FP_DW      = 8;
    localparam int FP_EXP_MAX = 255;
    localparam int FP_GRS_W   = 3;
    localparam int FP_AW      = FP_MW + FP_GRS_W;
    localparam int FP_SW      = FP_AW + 1;
    // Two extra bits so both exponent wrap directions stay visible as signed values
    localparam int FP_XW      = FP_EW + 2;
    localparam int FP_LW      = $clog2(FP_AW + 1);

    typedef struct packed {
        logic [FP_MW-1:0] a;
        logic [FP_EW-1:0] ae;
        logic             a_sign;
        logic             b_sign;
        logic [FP_AW-1:0] bx;
    } s1_t;

    typedef struct packed {
        logic [FP_SW-1:0] m;
        logic             sign;
        logic [FP_EW-1:0] ae;
    } s2_t;

    typedef struct packed {
        logic        ovf;
        logic        unf;
        logic [31:0] z;
    } s3_t;

    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, FP_EW'(FP_EXP_MAX), (FP_MW-1)'(0)};
    endfunction

    function automatic logic [31:0] fp_zero(input logic sign);
        return {sign, 31'h0};
    endfunction

endpackage

// File: rtl/fp_align_add_lzc.sv
// Combinational leading-zero counter; returns W when the input is all zero.
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_x,
    output logic [CW-1:0] o_cnt
);

    always_comb begin
        o_cnt = CW'(W);
        // Ascending scan: the highest set bit is the last one to write o_cnt
        for (int i = 0; i < W; i++) begin
            if (i_x[i]) begin
                o_cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_align_add.sv
// Align / add-sub / normalize-round back end producing a packed single, three
// register stages with a collapsing valid/ready chain.
module fp_align_add
    import fp_align_add_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [FP_MW-1:0] A,
    input  logic [FP_MW-1:0] B,
    input  logic [FP_EW-1:0] AE,
    input  logic [FP_EW-1:0] BE,
    input  logic             AS,
    input  logic             BS,
    input  logic [FP_DW-1:0] D,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      Z,
    output logic             OVF,
    output logic             UNF
);

    logic w_adv1, w_adv2, w_adv3;
    logic r_v1, r_v2, r_v3;
    s1_t  w_s1, r_s1;
    s2_t  w_s2, r_s2;
    s3_t  w_s3, r_s3;

    assign w_adv3   = ~r_v3 | OUT_READY;
    assign w_adv2   = ~r_v2 | w_adv3;
    assign w_adv1   = ~r_v1 | w_adv2;
    assign IN_READY = w_adv1;

    // ---------------- S1: align B ----------------
    logic [2*FP_AW-1:0] w_b_wide;
    logic [FP_AW-1:0]   w_bx;
    logic               w_be_unused;

    assign w_b_wide    = {B, {FP_GRS_W{1'b0}}, {FP_AW{1'b0}}} >> D;
    // BE only matters upstream; D already carries AE-BE
    assign w_be_unused = ^BE;

    always_comb begin
        w_bx = {w_b_wide[2*FP_AW-1:FP_AW+1], |w_b_wide[FP_AW:0]};
        if (D >= FP_DW'(FP_AW)) begin
            w_bx = {{(FP_AW-1){1'b0}}, |B};
        end
    end

    always_comb begin
        w_s1        = '0;
        w_s1.a      = A;
        w_s1.ae     = AE;
        w_s1.a_sign = AS;
        w_s1.b_sign = BS;
        w_s1.bx     = w_bx;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= IN_VALID;
            r_s1 <= w_s1;
        end
    end

    // ---------------- S2: magnitude add/sub ----------------
    logic [FP_SW-1:0] w_sum, w_dif;

    assign w_sum = {1'b0, r_s1.a, {FP_GRS_W{1'b0}}} + {1'b0, r_s1.bx};
    assign w_dif = {1'b0, r_s1.a, {FP_GRS_W{1'b0}}} - {1'b0, r_s1.bx};

    always_comb begin
        w_s2      = '0;
        w_s2.ae   = r_s1.ae;
        w_s2.sign = r_s1.a_sign;
        w_s2.m    = w_sum;
        if (r_s1.a_sign ^ r_s1.b_sign) begin
            w_s2.m = w_dif;
            // Only reachable with D=0 and B>A: the result takes B's sign
            if (w_dif[FP_SW-1]) begin
                w_s2.m    = -w_dif;
                w_s2.sign = r_s1.b_sign;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_v2 <= 1'b0;
            r_s2 <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            r_s2 <= w_s2;
        end
    end

    // ---------------- S3: normalize, round, pack ----------------
    logic [FP_LW-1:0]        w_lzc;
    logic [FP_AW-1:0]        w_norm;
    logic signed [FP_XW-1:0] w_exp_n, w_exp_r;
    logic [FP_MW:0]          w_rnd;
    logic [FP_MW-1:0]        w_mant;
    logic                    w_inc;

    fp_lzc #(.W(FP_AW)) u_lzc (
        .i_x   (r_s2.m[FP_AW-1:0]),
        .o_cnt (w_lzc)
    );

    always_comb begin
        w_norm  = r_s2.m[FP_AW-1:0] << w_lzc;
        w_exp_n = FP_XW'(r_s2.ae) - FP_XW'(w_lzc);
        if (r_s2.m[FP_SW-1]) begin
            w_norm  = {r_s2.m[FP_SW-1:2], r_s2.m[1] | r_s2.m[0]};
            w_exp_n = FP_XW'(r_s2.ae) + FP_XW'(1);
        end

        w_inc   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd   = {1'b0, w_norm[FP_AW-1:FP_GRS_W]} + (FP_MW+1)'(w_inc);
        w_mant  = w_rnd[FP_MW-1:0];
        w_exp_r = w_exp_n;
        if (w_rnd[FP_MW]) begin
            w_mant  = w_rnd[FP_MW:1];
            w_exp_r = w_exp_n + FP_XW'(1);
        end

        w_s3     = '0;
        w_s3.z   = {r_s2.sign, w_exp_r[FP_EW-1:0], w_mant[FP_MW-2:0]};
        if (r_s2.m == '0) begin
            w_s3.z = fp_zero(1'b0);
        end else if (w_exp_r >= FP_XW'(FP_EXP_MAX)) begin
            w_s3.z   = fp_inf(r_s2.sign);
            w_s3.ovf = 1'b1;
        end else if (w_exp_r <= FP_XW'(0)) begin
            w_s3.z   = fp_zero(r_s2.sign);
            w_s3.unf = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_v3 <= 1'b0;
            r_s3 <= '0;
        end else if (w_adv3) begin
            r_v3 <= r_v2;
            r_s3 <= w_s3;
        end
    end

    assign OUT_VALID = r_v3;
    assign Z         = r_s3.z;
    assign OVF       = r_s3.ovf;
    assign UNF       = r_s3.unf | (w_be_unused & 1'b0);

endmodule

// File: tb/tb_fp_align_add.sv
// Bench for fp_align_add: directed vectors, exact-arithmetic reference model for
// random traffic, backpressure and mid-stream reset sequences.
module tb_fp_align_add;

    typedef struct {
        logic [23:0] a, b;
        logic [7:0]  ae, be, d;
        logic        as_, bs;
        logic [31:0] z;
        logic        ovf, unf;
    } vec_t;

    logic        CLK = 1'b0, RST_N = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b1;
    logic        IN_READY, OUT_VALID, OVF, UNF;
    logic [23:0] A = '0, B = '0;
    logic [7:0]  AE = '0, BE = '0, D = '0;
    logic        AS = 1'b0, BS = 1'b0;
    logic [31:0] Z;

    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    fp_align_add dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .AE(AE), .BE(BE), .AS(AS), .BS(BS), .D(D),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Z(Z), .OVF(OVF), .UNF(UNF)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact sum of A*2^AE and B*2^BE in integers, then round-to-nearest-even to 24 bits.
    // Beyond ~27 bits of separation B only acts as a positive epsilon, so capping the
    // separation at 36 keeps the sum in 64 bits without changing the rounded result.
    function automatic logic [33:0] ref_model(input vec_t v);
        logic [63:0] da, db, mag, mant, rem, half;
        int dd, p, e, sh;
        logic sign;
        dd = (int'(v.d) > 36) ? 36 : int'(v.d);
        da = 64'(v.a) << dd;
        db = 64'(v.b);
        if (v.as_ == v.bs) begin mag = da + db; sign = v.as_; end
        else if (da >= db) begin mag = da - db; sign = v.as_; end
        else               begin mag = db - da; sign = v.bs;  end
        if (mag == 0) return 34'h0;
        p = 63;
        while (!mag[p]) p--;
        e = int'(v.ae) + p - 23 - dd;
        if (p > 23) begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 1;
        end else begin
            mant = mag << (23 - p);
        end
        if (mant[24]) begin mant = mant >> 1; e++; end
        if (e >= 255) return {2'b10, sign, 8'hFF, 23'h0};
        if (e <= 0)   return {2'b01, sign, 31'h0};
        return {2'b00, sign, 8'(e), mant[22:0]};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int sel, dd;
        sel = $urandom_range(0, 9);
        if (sel == 0)      v.ae = 8'($urandom_range(1, 4));
        else if (sel == 1) v.ae = 8'($urandom_range(250, 254));
        else               v.ae = 8'($urandom_range(1, 254));
        sel = $urandom_range(0, 9);
        if (sel < 3)      dd = $urandom_range(0, 2);
        else if (sel < 8) dd = $urandom_range(3, 30);
        else              dd = $urandom_range(0, 254);
        if (dd > int'(v.ae)) dd = int'(v.ae);
        v.d  = 8'(dd);
        v.be = v.ae - v.d;
        v.a  = {1'b1, 23'($urandom)};
        v.b  = {1'b1, 23'($urandom)};
        if (dd <= 1 && $urandom_range(0, 2) == 0) v.b = {1'b1, v.a[22:0] ^ 23'($urandom_range(0, 255))};
        if ($urandom_range(0, 15) == 0) v.b = '0;
        v.as_ = 1'($urandom);
        v.bs  = 1'($urandom);
        {v.ovf, v.unf, v.z} = ref_model(v);
        return v;
    endfunction

    task automatic put(input vec_t v);
        A = v.a; B = v.b; AE = v.ae; BE = v.be; D = v.d; AS = v.as_; BS = v.bs;
    endtask

    function automatic vec_t mk(input logic [23:0] a, input logic [7:0] ae, input logic as_,
                                input logic [23:0] b, input logic [7:0] be, input logic bs,
                                input logic [31:0] z, input logic ovf, input logic unf);
        vec_t v;
        v.a = a; v.ae = ae; v.as_ = as_; v.b = b; v.be = be; v.bs = bs;
        v.d = ae - be; v.z = z; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic apply_one(input vec_t v, input string name);
        int lat;
        @(negedge CLK);
        put(v);
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        #1;
        check({name, "_in_ready"}, IN_READY, 1);
        @(negedge CLK);
        IN_VALID = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_result"}, {OVF, UNF, Z}, {v.ovf, v.unf, v.z});
    endtask

    localparam int NT = 13;
    localparam int NR = 400;
    vec_t tbl[NT];

    initial begin
        vec_t bp[8];
        vec_t q[$];
        vec_t cur, ex;
        logic [33:0] held;
        logic hold_valid, saw_low, have, stale;
        int sent, got, cyc;

        tbl[0]  = mk(24'h800000, 127, 0, 24'h800000, 127, 0, 32'h4000_0000, 0, 0);
        tbl[1]  = mk(24'h800000, 127, 0, 24'h800000, 127, 1, 32'h0000_0000, 0, 0);
        tbl[2]  = mk(24'hC00000, 127, 0, 24'h800000,  97, 0, 32'h3FC0_0000, 0, 0);
        tbl[3]  = mk(24'h800000, 127, 0, 24'h800000, 103, 0, 32'h3F80_0000, 0, 0);
        tbl[4]  = mk(24'h800000, 127, 0, 24'h800001, 103, 0, 32'h3F80_0001, 0, 0);
        tbl[5]  = mk(24'hFFFFFF, 254, 0, 24'hFFFFFF, 254, 0, 32'h7F80_0000, 1, 0);
        tbl[6]  = mk(24'hFFFFFF, 254, 1, 24'hFFFFFF, 254, 1, 32'hFF80_0000, 1, 0);
        tbl[7]  = mk(24'h800000, 127, 0, 24'hC00000, 127, 1, 32'hBF00_0000, 0, 0);
        tbl[8]  = mk(24'h800000,   1, 0, 24'hC00000,   1, 1, 32'h8000_0000, 0, 1);
        tbl[9]  = mk(24'h800000, 128, 0, 24'h800000, 127, 0, 32'h4040_0000, 0, 0);
        tbl[10] = mk(24'h000000,   0, 0, 24'h000000,   0, 0, 32'h0000_0000, 0, 0);
        tbl[11] = mk(24'h800000, 127, 0, 24'h800000,  97, 1, 32'h3F80_0000, 0, 0);
        tbl[12] = mk(24'h800001, 127, 0, 24'h800000, 103, 0, 32'h3F80_0002, 0, 0);

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_outputs", {OUT_VALID, OVF, UNF, Z}, 35'h0);
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_in_ready", IN_READY, 1);

        for (int i = 0; i < NT; i++) apply_one(tbl[i], $sformatf("tbl%0d", i));

        // Backpressure: 8 bundles, output stalled on stream cycles 4..7
        for (int i = 0; i < 8; i++) bp[i] = rand_vec();
        sent = 0; got = 0; cyc = 0; hold_valid = 1'b0; saw_low = 1'b0; held = '0;
        while (got < 8 && cyc < 100) begin
            @(negedge CLK);
            if (hold_valid) check("bp_stall_hold", {OUT_VALID, OVF, UNF, Z}, {1'b1, held});
            OUT_READY = !(cyc >= 4 && cyc <= 7);
            if (sent < 8) begin put(bp[sent]); IN_VALID = 1'b1; end
            else IN_VALID = 1'b0;
            #1;
            if (!IN_READY) saw_low = 1'b1;
            if (IN_VALID && IN_READY) sent++;
            if (OUT_VALID && OUT_READY) begin
                check($sformatf("bp_order%0d", got), {OVF, UNF, Z}, {bp[got].ovf, bp[got].unf, bp[got].z});
                got++;
            end
            hold_valid = OUT_VALID && !OUT_READY;
            held = {OVF, UNF, Z};
            cyc++;
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        check("bp_count", got, 8);
        check("bp_in_ready_dropped", saw_low, 1);
        repeat (2) @(negedge CLK);
        check("bp_no_duplicate", OUT_VALID, 0);

        // Random traffic against the reference model
        sent = 0; got = 0; cyc = 0; have = 1'b0;
        while (got < NR && cyc < 5000) begin
            @(negedge CLK);
            if (sent < NR && !have) begin cur = rand_vec(); have = 1'b1; end
            IN_VALID  = have && ($urandom_range(0, 9) < 7);
            OUT_READY = ($urandom_range(0, 3) != 0);
            put(cur);
            #1;
            if (IN_VALID && IN_READY) begin q.push_back(cur); sent++; have = 1'b0; end
            if (OUT_VALID && OUT_READY) begin
                if (q.size() == 0) check("rnd_spurious", OUT_VALID, 0);
                else begin
                    ex = q.pop_front();
                    check($sformatf("rnd%0d a=%h ae=%0d as=%b b=%h d=%0d bs=%b", got, ex.a, ex.ae, ex.as_, ex.b, ex.d, ex.bs),
                          {OVF, UNF, Z}, {ex.ovf, ex.unf, ex.z});
                    got++;
                end
            end
            cyc++;
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        check("rnd_count", got, NR);

        // Reset in the middle of a full, stalled pipe
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            put(rand_vec());
            IN_VALID = 1'b1;
        end
        @(negedge CLK);
        check("rst_pipe_full", OUT_VALID, 1);
        #2 RST_N = 1'b0;
        #1 check("rst_async_valid", OUT_VALID, 0);
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("rst_mid_outputs", {OUT_VALID, OVF, UNF, Z}, 35'h0);
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (OUT_VALID) stale = 1'b1;
        end
        check("rst_no_stale", stale, 0);
        check("rst_in_ready_after", IN_READY, 1);
        apply_one(tbl[9], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
